// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, types and helpers for the BRAM-based buffers.
//   fifo_cnt_w(depth) : width of a FIFO occupancy count covering BRAM, the
//                       in-flight read and the output stage (0..depth+2).
//   FIFO_SKID_ENTRIES : number of entries in the FIFO output stage.
//   stage_cnt_t       : output-stage occupancy (0..2).
package mem_pkg;

  localparam int FIFO_SKID_ENTRIES = 2;

  typedef logic [1:0] stage_cnt_t;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/bram_block.sv
// bram_block: multi-port synchronous RAM array with registered read data.
//   clk   : clock, all ports sample on the rising edge
//   we    : per-port write enable
//   addr  : per-port address
//   wdata : per-port write data
//   rdata : per-port read data, mem[addr] registered one cycle after addr
// Contents are not reset.
module bram_block #(
  parameter int NUM_PORTS = 2,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic [NUM_PORTS-1:0]                we,
  input  logic [NUM_PORTS-1:0][AW-1:0]        addr,
  input  logic [NUM_PORTS-1:0][WIDTH-1:0]     wdata,
  output logic [NUM_PORTS-1:0][WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0]                 mem [DEPTH];
  logic [NUM_PORTS-1:0][WIDTH-1:0]  rdata_q;

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (we[p]) begin
        mem[addr[p]] <= wdata[p];
      end
      rdata_q[p] <= mem[addr[p]];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bram_fifo.sv
// bram_fifo: first-word-fall-through valid/ready FIFO on a two-port BRAM.
// Port 0 of the array writes, port 1 reads; the 1-cycle registered read is
// hidden behind a 2-entry output stage (head + skid) for full throughput.
//   clk, reset (async active-low), flush (sync clear, highest priority)
//   wr_valid / wr_ready / wr_data : producer side, wr_ready registered
//   rd_valid / rd_ready / rd_data : consumer side, rd_data = head entry
//   count : entries held in BRAM + in-flight read + output stage
// Optional macro BRAM_FIFO_BYPASS_EN: a write into a completely empty FIFO
// lands directly in the head register (latency 1 instead of 3).
module bram_fifo
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [WIDTH-1:0]              rd_data,
  output logic [fifo_cnt_w(DEPTH)-1:0]  count
);

  localparam int            AW        = $clog2(DEPTH);
  localparam int            CW        = fifo_cnt_w(DEPTH);
  localparam int            NUM_PORTS = 2;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d, count_q, count_d;
  logic             pending_q, pending_d;
  stage_cnt_t       stage_cnt_q, stage_cnt_d;
  logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic             wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;

  logic             wr_fire, pop, bypass, bram_wr, fetch;
  logic [2:0]       stage_need;
  stage_cnt_t       stage_after;

  logic [NUM_PORTS-1:0]             bram_we;
  logic [NUM_PORTS-1:0][AW-1:0]     bram_addr;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  bram_wdata, bram_rdata;
  logic [WIDTH-1:0]                 port0_rdata_unused;

  always_comb begin
    wr_fire = wr_valid && wr_ready_q;
    pop     = rd_valid_q && rd_ready;
`ifdef BRAM_FIFO_BYPASS_EN
    bypass  = wr_fire && (count_q == '0) && !flush;
`else
    bypass  = 1'b0;
`endif
    bram_wr = wr_fire && !bypass && !flush;

    // Stage slots already claimed (held or in flight), minus the one a pop frees.
    stage_need = {1'b0, stage_cnt_q} + {2'b00, pending_q};
    fetch      = (mem_cnt_q != '0) && !flush &&
                 (stage_need < (3'(FIFO_SKID_ENTRIES) + {2'b00, pop}));

    wr_ptr_d  = wr_ptr_q + AW'(bram_wr);
    rd_ptr_d  = rd_ptr_q + AW'(fetch);
    mem_cnt_d = mem_cnt_q + CW'(bram_wr) - CW'(fetch);
    pending_d = fetch;

    stage_after = stage_cnt_q - stage_cnt_t'(pop);
    head_d      = head_q;
    skid_d      = skid_q;
    if (pop && (stage_cnt_q == stage_cnt_t'(FIFO_SKID_ENTRIES))) begin
      head_d = skid_q;
    end
    // Returning read data fills whichever slot is the tail after the pop.
    if (pending_q) begin
      if (stage_after == '0) begin
        head_d = bram_rdata[1];
      end else begin
        skid_d = bram_rdata[1];
      end
    end
    if (bypass) begin
      head_d = wr_data;
    end
    stage_cnt_d = stage_after + stage_cnt_t'(pending_q) + stage_cnt_t'(bypass);

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_cnt_d   = '0;
      pending_d   = 1'b0;
      stage_cnt_d = '0;
    end

    wr_ready_d = (mem_cnt_d < DEPTH_C);
    rd_valid_d = (stage_cnt_d != '0);
    count_d    = mem_cnt_d + CW'(pending_d) + CW'(stage_cnt_d);

    bram_we       = {1'b0, bram_wr};
    bram_addr[0]  = wr_ptr_q;
    bram_addr[1]  = rd_ptr_q;
    bram_wdata[0] = wr_data;
    bram_wdata[1] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      count_q     <= '0;
      pending_q   <= 1'b0;
      stage_cnt_q <= '0;
      head_q      <= '0;
      skid_q      <= '0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      stage_cnt_q <= stage_cnt_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  bram_block #(
    .NUM_PORTS (NUM_PORTS),
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH)
  ) u_bram (
    .clk   (clk),
    .we    (bram_we),
    .addr  (bram_addr),
    .wdata (bram_wdata),
    .rdata (bram_rdata)
  );

  assign port0_rdata_unused = bram_rdata[0];

  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = head_q;
  assign count    = count_q;

endmodule
